// File: rtl/game_sequencer.sv
// Duck-runner game controller: sequences core through IDLE/RUN/PAUSE/OVER,
// paces speed and BCD score from the frame tick, and tracks the high score.
//
// state | meaning
// IDLE  | power-up, waiting for the first start press
// RUN   | game active, core moving, score/speed advancing per frame
// PAUSE | game frozen, collisions ignored, everything holds
// OVER  | collision ended the game; restart locked out for OVER_FRAMES frames
module game_sequencer #(
  parameter int SCORE_DIV   = 6,
  parameter int RAMP_FRAMES = 600,
  parameter int SPEED_MIN   = 2,
  parameter int SPEED_MAX   = 8,
  parameter int OVER_FRAMES = 120
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame,
  input  logic        start_pulse,
  input  logic        pause_pulse,
  input  logic        collide,
  output logic [1:0]  state,
  output logic        run_en,
  output logic        game_clear,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic        new_hi
);

  localparam int SC_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int RP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam int OV_W = $clog2(OVER_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t          state_q, state_n;
  logic            run_en_q, run_en_n;
  logic            clear_q, clear_n;
  logic [3:0]      speed_q, speed_n;
  logic [15:0]     score_q, score_n;
  logic [15:0]     hi_q, hi_n;
  logic            new_hi_q, new_hi_n;
  logic [SC_W-1:0] score_cnt_q, score_cnt_n;
  logic [RP_W-1:0] ramp_cnt_q, ramp_cnt_n;
  logic [OV_W-1:0] over_cnt_q, over_cnt_n;
  logic            coll_q, coll_n;
  logic            start_game;

  // Packed 4-digit BCD increment with ripple carry; holds at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      run_en_q    <= 1'b0;
      clear_q     <= 1'b0;
      speed_q     <= 4'(SPEED_MIN);
      score_q     <= 16'h0000;
      hi_q        <= 16'h0000;
      new_hi_q    <= 1'b0;
      score_cnt_q <= '0;
      ramp_cnt_q  <= '0;
      over_cnt_q  <= '0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      run_en_q    <= run_en_n;
      clear_q     <= clear_n;
      speed_q     <= speed_n;
      score_q     <= score_n;
      hi_q        <= hi_n;
      new_hi_q    <= new_hi_n;
      score_cnt_q <= score_cnt_n;
      ramp_cnt_q  <= ramp_cnt_n;
      over_cnt_q  <= over_cnt_n;
      coll_q      <= coll_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    clear_n     = 1'b0;
    speed_n     = speed_q;
    score_n     = score_q;
    hi_n        = hi_q;
    new_hi_n    = new_hi_q;
    score_cnt_n = score_cnt_q;
    ramp_cnt_n  = ramp_cnt_q;
    over_cnt_n  = over_cnt_q;
    coll_n      = coll_q;
    start_game  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_pulse) start_game = 1'b1;
      end

      S_RUN: begin
        if (collide) coll_n = 1'b1;
        if (frame) begin
          if (coll_q || collide) begin
            state_n    = S_OVER;
            over_cnt_n = '0;
            // Packed BCD orders correctly as plain unsigned binary.
            if (score_q > hi_q) begin
              hi_n     = score_q;
              new_hi_n = 1'b1;
            end
          end else begin
            if (score_cnt_q == SC_W'(SCORE_DIV - 1)) begin
              score_cnt_n = '0;
              score_n     = bcd_inc(score_q);
            end else begin
              score_cnt_n = score_cnt_q + 1'b1;
            end
            if (ramp_cnt_q == RP_W'(RAMP_FRAMES - 1)) begin
              ramp_cnt_n = '0;
              if (speed_q < 4'(SPEED_MAX)) speed_n = speed_q + 4'd1;
            end else begin
              ramp_cnt_n = ramp_cnt_q + 1'b1;
            end
          end
        end else if (pause_pulse) begin
          state_n = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (start_pulse || pause_pulse) state_n = S_RUN;
      end

      S_OVER: begin
        if (frame && (over_cnt_q < OV_W'(OVER_FRAMES))) over_cnt_n = over_cnt_q + 1'b1;
        if (start_pulse && (over_cnt_q >= OV_W'(OVER_FRAMES))) start_game = 1'b1;
      end

      default: state_n = S_IDLE;
    endcase

    if (start_game) begin
      state_n     = S_RUN;
      clear_n     = 1'b1;
      score_n     = 16'h0000;
      speed_n     = 4'(SPEED_MIN);
      new_hi_n    = 1'b0;
      score_cnt_n = '0;
      ramp_cnt_n  = '0;
      over_cnt_n  = '0;
      coll_n      = 1'b0;
    end

    run_en_n = (state_n == S_RUN);
  end

  assign state      = state_q;
  assign run_en     = run_en_q;
  assign game_clear = clear_q;
  assign speed      = speed_q;
  assign score      = score_q;
  assign hi_score   = hi_q;
  assign new_hi     = new_hi_q;

endmodule
